// File: rtl/workload_traffic_gen.sv
// Multi-port workload token source: issues {id, size} tokens on valid/ready channels
// under a global limit and an outstanding cap. Define WORKLOAD_TRAFFIC_GEN_STATS_EN for stall/active counters.
module workload_traffic_gen #(
  parameter int          id_width_p        = 8,
  parameter int          size_width_p      = 8,
  parameter int          num_ports_p       = 2,
  parameter int          workload_limit_p  = 30,
  parameter int          max_outstanding_p = 8,
  parameter int          mode_p            = 0,
  parameter logic [15:0] lfsr_seed_p       = 16'hACE1
) (
  input  logic                                                   clk_i,
  input  logic                                                   reset_i,
  output logic [num_ports_p-1:0]                                 v_o,
  output logic [num_ports_p-1:0][id_width_p+size_width_p-1:0]    data_o,
  input  logic [num_ports_p-1:0]                                 ready_i,
  input  logic                                                   cpl_v_i,
  input  logic [id_width_p-1:0]                                  cpl_id_i,
  output logic                                                   done_o,
  output logic                                                   err_o
`ifdef WORKLOAD_TRAFFIC_GEN_STATS_EN
  ,
  output logic [31:0]                                            stall_cycles_o,
  output logic [31:0]                                            active_cycles_o
`endif
);

  localparam int W       = id_width_p + size_width_p;
  localparam int CNT_MAX = (workload_limit_p > max_outstanding_p) ? workload_limit_p : max_outstanding_p;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = (num_ports_p > 1) ? $clog2(num_ports_p) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(workload_limit_p);
  localparam logic [CW-1:0] MAXO  = CW'(max_outstanding_p);

  // Handshake: a token on port p transfers on a rising edge where v_o[p] & ready_i[p];
  // once v_o[p] rises, it and data_o[p] hold until that transfer. Completions are always accepted.
  logic [num_ports_p-1:0]        v_q;
  logic [num_ports_p-1:0][W-1:0] data_q;
  logic [CW-1:0]                 gen_cnt;
  logic [CW-1:0]                 cpl_cnt;
  logic [CW-1:0]                 in_flight;
  logic [PW-1:0]                 rr_ptr;
  logic [15:0]                   lfsr_q;
  logic                          done_q;
  logic                          err_q;

  logic [num_ports_p-1:0]        slot_free;
  logic [PW-1:0]                 tgt;
  logic                          tgt_found;
  logic                          gen;
  logic                          cpl_ok;
  logic [id_width_p-1:0]         gen_id;
  logic [size_width_p-1:0]       lfsr_size;
  logic [size_width_p-1:0]       gen_size;
  logic                          lfsr_fb;
  logic                          unused_cpl_id;

  assign unused_cpl_id = ^cpl_id_i;

  // A slot draining this cycle counts as free so it can be reloaded without a bubble.
  always_comb begin
    slot_free = ~v_q | ready_i;
    tgt       = rr_ptr;
    tgt_found = 1'b0;
    if (mode_p == 0) begin
      tgt_found = slot_free[rr_ptr];
    end else begin
      // Walk downward so the nearest free slot from rr_ptr wins.
      for (int i = num_ports_p - 1; i >= 0; i--) begin
        if (slot_free[PW'((int'(rr_ptr) + i) % num_ports_p)]) begin
          tgt       = PW'((int'(rr_ptr) + i) % num_ports_p);
          tgt_found = 1'b1;
        end
      end
    end
  end

  assign gen       = (gen_cnt < LIMIT) && (in_flight < MAXO) && tgt_found;
  assign cpl_ok    = cpl_v_i && (in_flight != '0);
  assign gen_id    = id_width_p'(gen_cnt);
  assign lfsr_size = size_width_p'(lfsr_q);
  assign gen_size  = (lfsr_size == '0) ? size_width_p'(1) : lfsr_size;
  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      v_q    <= '0;
      data_q <= '0;
    end else begin
      for (int p = 0; p < num_ports_p; p++) begin
        if (gen && (int'(tgt) == p)) begin
          v_q[p]    <= 1'b1;
          data_q[p] <= {gen_id, gen_size};
        end else if (v_q[p] && ready_i[p]) begin
          v_q[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      gen_cnt   <= '0;
      cpl_cnt   <= '0;
      in_flight <= '0;
      rr_ptr    <= '0;
      lfsr_q    <= lfsr_seed_p;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (gen) begin
        gen_cnt <= gen_cnt + 1'b1;
        lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
        rr_ptr  <= PW'((int'(tgt) + 1) % num_ports_p);
      end
      if (gen && !cpl_ok && (in_flight != '1)) begin
        in_flight <= in_flight + 1'b1;
      end else if (!gen && cpl_ok) begin
        in_flight <= in_flight - 1'b1;
      end
      if (cpl_ok && (cpl_cnt != '1)) begin
        cpl_cnt <= cpl_cnt + 1'b1;
      end
      if (cpl_v_i && (in_flight == '0)) begin
        err_q <= 1'b1;
      end
      if ((cpl_cnt == LIMIT) && (v_q == '0)) begin
        done_q <= 1'b1;
      end
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;
  assign done_o = done_q;
  assign err_o  = err_q;

`ifdef WORKLOAD_TRAFFIC_GEN_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] active_q;
  logic        stall_now;

  assign stall_now = |(v_q & ~ready_i);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stall_q  <= '0;
      active_q <= '0;
    end else begin
      if (stall_now && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (!done_q && (active_q != '1)) begin
        active_q <= active_q + 32'd1;
      end
    end
  end

  assign stall_cycles_o  = stall_q;
  assign active_cycles_o = active_q;
`endif

endmodule

// File: tb/tb_workload_traffic_gen.sv
// Bench for workload_traffic_gen: three instances (strict RR, work-conserving RR, outstanding cap 4)
// checked every cycle against a token-level model, plus hand-computed literal expectations.
module tb_workload_traffic_gen;

  localparam int N     = 2;
  localparam int W     = 16;
  localparam int LIMIT = 30;
  localparam int NI    = 3;
  localparam int MODE [NI] = '{0, 1, 0};
  localparam int MAXO [NI] = '{8, 8, 4};

  // clock / reset
  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]        rdy  [NI];
  logic                cplv [NI];
  logic [7:0]          cid  [NI];
  logic [N-1:0]        v    [NI];
  logic [N-1:0][W-1:0] data [NI];
  logic                done [NI];
  logic                err  [NI];
  bit                  auto_en [NI];
`ifdef WORKLOAD_TRAFFIC_GEN_STATS_EN
  logic [31:0] stall_c [NI];
  logic [31:0] active_c [NI];
`endif

  workload_traffic_gen #(.mode_p(0), .max_outstanding_p(8)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .v_o(v[0]), .data_o(data[0]), .ready_i(rdy[0]),
    .cpl_v_i(cplv[0]), .cpl_id_i(cid[0]), .done_o(done[0]), .err_o(err[0])
`ifdef WORKLOAD_TRAFFIC_GEN_STATS_EN
    , .stall_cycles_o(stall_c[0]), .active_cycles_o(active_c[0])
`endif
  );
  workload_traffic_gen #(.mode_p(1), .max_outstanding_p(8)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .v_o(v[1]), .data_o(data[1]), .ready_i(rdy[1]),
    .cpl_v_i(cplv[1]), .cpl_id_i(cid[1]), .done_o(done[1]), .err_o(err[1])
`ifdef WORKLOAD_TRAFFIC_GEN_STATS_EN
    , .stall_cycles_o(stall_c[1]), .active_cycles_o(active_c[1])
`endif
  );
  workload_traffic_gen #(.mode_p(0), .max_outstanding_p(4)) dut_c (
    .clk_i(clk), .reset_i(reset_i), .v_o(v[2]), .data_o(data[2]), .ready_i(rdy[2]),
    .cpl_v_i(cplv[2]), .cpl_id_i(cid[2]), .done_o(done[2]), .err_o(err[2])
`ifdef WORKLOAD_TRAFFIC_GEN_STATS_EN
    , .stall_cycles_o(stall_c[2]), .active_cycles_o(active_c[2])
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d t=%0t got=%h want=%h", name, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_v    [NI];
  logic [W-1:0] m_data [NI][N];
  int           m_gen  [NI];
  int           m_cpl  [NI];
  int           m_inf  [NI];
  int           m_rr   [NI];
  logic [15:0]  m_lfsr [NI];
  bit           m_done [NI];
  bit           m_err  [NI];

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_reset(input int k);
    m_v[k] = '0;
    for (int p = 0; p < N; p++) m_data[k][p] = '0;
    m_gen[k] = 0; m_cpl[k] = 0; m_inf[k] = 0; m_rr[k] = 0;
    m_lfsr[k] = 16'hACE1; m_done[k] = 1'b0; m_err[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    logic [N-1:0] drain;
    int tgt, p;
    bit do_gen, cpl_ok;
    logic [7:0] sz;
    drain = m_v[k] & rdy[k];
    tgt = -1;
    // strict mode only looks at the pointed slot; work-conserving scans onward with wrap
    for (int i = 0; i < N; i++) begin
      p = (m_rr[k] + i) % N;
      if (tgt < 0 && (!m_v[k][p] || drain[p]) && (MODE[k] == 1 || i == 0)) tgt = p;
    end
    do_gen = (m_gen[k] < LIMIT) && (m_inf[k] < MAXO[k]) && (tgt >= 0);
    cpl_ok = cplv[k] && (m_inf[k] > 0);
    if (m_cpl[k] == LIMIT && m_v[k] == '0) m_done[k] = 1'b1;
    if (cplv[k] && m_inf[k] == 0) m_err[k] = 1'b1;
    m_v[k] = m_v[k] & ~drain;
    if (do_gen) begin
      sz = m_lfsr[k][7:0];
      if (sz == 8'd0) sz = 8'd1;
      m_v[k][tgt] = 1'b1;
      m_data[k][tgt] = {8'(m_gen[k] % 256), sz};
      m_lfsr[k] = lfsr_next(m_lfsr[k]);
      m_rr[k] = (tgt + 1) % N;
      m_gen[k]++;
    end
    m_inf[k] = m_inf[k] + int'(do_gen) - int'(cpl_ok);
    if (cpl_ok) m_cpl[k]++;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) model_reset(k);
    forever begin
      @(posedge clk);
      for (int k = 0; k < NI; k++) begin
        if (!reset_i) model_reset(k);
        else model_step(k);
      end
    end
  end

  // per-cycle compare of DUT outputs against the model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
        check("v_o", k, 32'(v[k]), 32'(m_v[k]));
        for (int p = 0; p < N; p++)
          if (m_v[k][p]) check("data_o", k, 32'(data[k][p]), 32'(m_data[k][p]));
        check("done_o", k, 32'(done[k]), 32'(m_done[k]));
        check("err_o", k, 32'(err[k]), 32'(m_err[k]));
      end
    end
  end

  // ---------------- accept monitor and completion driver ----------------
  int           cyc = 0;
  logic [W-1:0] acc_data [NI][$];
  int           acc_port [NI][$];
  int           due_q    [NI][$];
  logic [7:0]   due_id   [NI][$];
  logic [W-1:0] exp_q[$];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset_i) begin
        for (int k = 0; k < NI; k++)
          for (int p = 0; p < N; p++)
            if (v[k][p] && rdy[k][p]) begin
              acc_data[k].push_back(data[k][p]);
              acc_port[k].push_back(p);
              due_q[k].push_back(cyc + 2);
              due_id[k].push_back(data[k][p][15:8]);
            end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (auto_en[k]) begin
          if (due_q[k].size() > 0 && due_q[k][0] <= cyc) begin
            cplv[k] = 1'b1;
            cid[k] = due_id[k].pop_front();
            void'(due_q[k].pop_front());
          end else begin
            cplv[k] = 1'b0;
          end
        end
      end
    end
  end

  task automatic clear_logs();
    for (int k = 0; k < NI; k++) begin
      acc_data[k].delete(); acc_port[k].delete();
      due_q[k].delete(); due_id[k].delete();
    end
  endtask

  task automatic pulse_cpl(input int k);
    cplv[k] = 1'b1;
    @(negedge clk);
    cplv[k] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog t=%0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int b_ids [7];
    b_ids = '{0, 2, 3, 4, 5, 6, 7};
    for (int k = 0; k < NI; k++) begin
      rdy[k] = '0; cplv[k] = 1'b0; cid[k] = '0; auto_en[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst_v", k, 32'(v[k]), 32'd0);
      check("rst_data", k, 32'(data[k]), 32'd0);
      check("rst_done", k, 32'(done[k]), 32'd0);
      check("rst_err", k, 32'(err[k]), 32'd0);
    end

    // phase 1: A full run with completions, B/C stall scenarios
    rdy[0] = 2'b11; rdy[1] = 2'b01; rdy[2] = 2'b11; auto_en[0] = 1'b1;
    reset_i = 1'b1;
    repeat (20) @(negedge clk);
    check("b_acc_cnt", 1, 32'(acc_data[1].size()), 32'd7);
    for (int i = 0; i < 7 && i < acc_data[1].size(); i++) begin
      check("b_acc_id", 1, 32'(acc_data[1][i][15:8]), 32'(b_ids[i]));
      check("b_acc_port", 1, 32'(acc_port[1][i]), 32'd0);
    end
    check("b_held_v", 1, 32'(v[1]), 32'b10);
    check("b_held_id", 1, 32'(data[1][1][15:8]), 32'd1);
    check("c_cap_cnt", 2, 32'(acc_data[2].size()), 32'd4);
    check("c_cap_v", 2, 32'(v[2]), 32'd0);
    pulse_cpl(2);
    rdy[1] = 2'b11;
    repeat (5) @(negedge clk);
    check("c_one_more", 2, 32'(acc_data[2].size()), 32'd5);
    if (acc_data[2].size() == 5) check("c_last_id", 2, 32'(acc_data[2][4][15:8]), 32'd4);
    check("b_id1_cnt", 1, 32'(acc_data[1].size()), 32'd8);
    if (acc_data[1].size() == 8) begin
      check("b_id1_id", 1, 32'(acc_data[1][7][15:8]), 32'd1);
      check("b_id1_port", 1, 32'(acc_port[1][7]), 32'd1);
    end

    for (int i = 0; i < 300 && !done[0]; i++) @(negedge clk);
    check("a_done", 0, 32'(done[0]), 32'd1);
    check("a_err", 0, 32'(err[0]), 32'd0);
    for (int i = 0; i < LIMIT; i++) exp_q.push_back({8'(i), 8'h00});
    check("a_acc_cnt", 0, 32'(acc_data[0].size()), 32'(LIMIT));
    for (int i = 0; i < LIMIT && i < acc_data[0].size(); i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("a_id", 0, 32'(acc_data[0][i][15:8]), 32'(e[15:8]));
      check("a_port", 0, 32'(acc_port[0][i]), 32'(i % 2));
      check("a_size_nz", 0, 32'(acc_data[0][i][7:0] != 8'd0), 32'd1);
    end
    if (acc_data[0].size() >= 3) begin
      check("a_size0", 0, 32'(acc_data[0][0][7:0]), 32'hE1);
      check("a_size1", 0, 32'(acc_data[0][1][7:0]), 32'hC3);
      check("a_size2", 0, 32'(acc_data[0][2][7:0]), 32'h87);
    end
    auto_en[0] = 1'b0;
    pulse_cpl(0);
    @(negedge clk);
    check("a_err_set", 0, 32'(err[0]), 32'd1);
    repeat (3) @(negedge clk);
    check("a_err_hold", 0, 32'(err[0]), 32'd1);
    check("a_done_hold", 0, 32'(done[0]), 32'd1);

    // phase 2: strict RR with port 1 blocked; gen+cpl at in_flight 3 on C
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    rdy[0] = 2'b01; rdy[1] = 2'b01; rdy[2] = 2'b11;
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    pulse_cpl(2);
    repeat (16) @(negedge clk);
    check("a_p0_cnt", 0, 32'(acc_data[0].size()), 32'd2);
    if (acc_data[0].size() == 2) begin
      check("a_p0_id0", 0, 32'(acc_data[0][0][15:8]), 32'd0);
      check("a_p0_id1", 0, 32'(acc_data[0][1][15:8]), 32'd2);
    end
    check("a_stall_v", 0, 32'(v[0]), 32'b10);
    check("a_stall_id", 0, 32'(data[0][1][15:8]), 32'd1);
    check("c_simul_cnt", 2, 32'(acc_data[2].size()), 32'd5);
    check("c_simul_v", 2, 32'(v[2]), 32'd0);

    // phase 3: reset mid-run discards pending tokens
    rdy[0] = 2'b11; rdy[1] = 2'b11; rdy[2] = 2'b11;
    repeat (4) @(negedge clk);
    reset_i = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) check("midrst_v", k, 32'(v[k]), 32'd0);
`ifdef WORKLOAD_TRAFFIC_GEN_STATS_EN
    check("midrst_stall", 0, stall_c[0], 32'd0);
    check("midrst_active", 0, active_c[0], 32'd0);
`endif
    @(negedge clk);
    clear_logs();
    auto_en[0] = 1'b1;
    @(negedge clk);
    reset_i = 1'b1;
    repeat (4) @(negedge clk);
    check("rerun_cnt", 0, 32'(acc_data[0].size() > 0), 32'd1);
    if (acc_data[0].size() > 0) begin
      check("rerun_first", 0, 32'(acc_data[0][0]), 32'h00E1);
      check("rerun_port", 0, 32'(acc_port[0][0]), 32'd0);
    end
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
